// File: rtl/sel_decode_pkg.sv
// Package: sel_decode_pkg
// Shared widths and types for the registered 3-to-8 row-select decoder.
package sel_decode_pkg;

    localparam int ADR_W = 3;
    localparam int SEL_N = 8;

    typedef logic [ADR_W-1:0] adr_t;
    typedef logic [SEL_N-1:0] sel_t;

    // Value driven on every row-select line when no row is selected.
    localparam sel_t SEL_NONE = '0;

endpackage : sel_decode_pkg

// File: rtl/sel_decode_core.sv
// Module: sel_decode_core
// Purely combinational 3-to-8 one-hot decode of a qualified word address.
// With valid=0 no row is selected.
module sel_decode_core
    import sel_decode_pkg::*;
(
    input  logic [ADR_W-1:0] adr,
    input  logic             valid,
    output logic [SEL_N-1:0] sel
);

    // Decode the address into a single active-high row select.
    always_comb begin
        // NOTE: default assignment first so every path drives sel; otherwise a latch is inferred.
        sel = SEL_NONE;
        if (valid) begin
            sel[adr] = 1'b1;
        end
    end

endmodule : sel_decode_core

// File: rtl/sel_decode.sv
// Module: sel_decode
// Registered 3-to-8 one-hot row-select decoder for the 8x8 bit memory array.
// One clock of latency from a qualified address to its row select; reset is
// asynchronous and active-high and clears every select line.
// Build option: define SEL_DECODE_HOLD_EN to keep the last decoded row
// selected while valid=0 (reset still clears it). Undefined, valid=0 clears
// all selects on the next edge.
module sel_decode
    import sel_decode_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_adr0,
    input  logic i_adr1,
    input  logic i_adr2,
    input  logic valid,
    output logic o_adr0,
    output logic o_adr1,
    output logic o_adr2,
    output logic o_adr3,
    output logic o_adr4,
    output logic o_adr5,
    output logic o_adr6,
    output logic o_adr7
);

    adr_t adrPacked;
    sel_t selNext;
    sel_t selReg;

    // Gather the individual address pins into one unsigned word address.
    assign adrPacked = {i_adr2, i_adr1, i_adr0};

    sel_decode_core uDecode (
        .adr   (adrPacked),
        .valid (valid),
        .sel   (selNext)
    );

    // Select register: cleared asynchronously by reset, loaded every edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
            selReg <= SEL_NONE;
`ifdef SEL_DECODE_HOLD_EN
        end else if (valid) begin
            // Idle cycles leave the last decoded row selected.
            selReg <= selNext;
        end
`else
        end else begin
            // The decoder already yields all-zero when valid=0.
            selReg <= selNext;
        end
`endif
    end

    // Drive the word-line select outputs straight from the register.
    assign o_adr0 = selReg[0];
    assign o_adr1 = selReg[1];
    assign o_adr2 = selReg[2];
    assign o_adr3 = selReg[3];
    assign o_adr4 = selReg[4];
    assign o_adr5 = selReg[5];
    assign o_adr6 = selReg[6];
    assign o_adr7 = selReg[7];

endmodule : sel_decode

// File: tb/tb_sel_decode.sv
// Testbench: tb_sel_decode
// Self-checking bench for sel_decode. A behavioural model tracks which row
// (if any) must be selected and is compared against the outputs every cycle;
// directed steps pin the model with hand-computed literal values.
// Honours SEL_DECODE_HOLD_EN the same way the design does.
module tb_sel_decode;

`ifdef SEL_DECODE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       i_clk;
    logic       i_rst;
    logic [2:0] adr;
    logic       valid;
    logic       o_adr0, o_adr1, o_adr2, o_adr3, o_adr4, o_adr5, o_adr6, o_adr7;
    logic [7:0] outVec;

    int nChecks = 0;
    int nFail   = 0;

    // Model state: index of the row that must be selected, -1 for none.
    int expRow = -1;

    sel_decode dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adr0 (adr[0]),
        .i_adr1 (adr[1]),
        .i_adr2 (adr[2]),
        .valid  (valid),
        .o_adr0 (o_adr0),
        .o_adr1 (o_adr1),
        .o_adr2 (o_adr2),
        .o_adr3 (o_adr3),
        .o_adr4 (o_adr4),
        .o_adr5 (o_adr5),
        .o_adr6 (o_adr6),
        .o_adr7 (o_adr7)
    );

    assign outVec = {o_adr7, o_adr6, o_adr5, o_adr4, o_adr3, o_adr2, o_adr1, o_adr0};

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [7:0] rowToSel(int row);
        logic [7:0] v;
        v = 8'h00;
        if (row >= 0 && row < 8) v[row] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: which row the decoder must be selecting.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       expRow = -1;
        else if (valid)  expRow = int'(adr);
        else if (!HOLD)  expRow = -1;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge i_clk) begin
        check("cycle", outVec, rowToSel(expRow));
    end

    // Invariant: never more than one row selected.
    always @(negedge i_clk) begin
        assert ($onehot0(outVec)) else $error("onehot0 violated: %b", outVec);
    end

    // Address must be known whenever it is being decoded.
    always @(posedge i_clk) begin
        if (!i_rst && valid === 1'b1)
            assert (!$isunknown(adr)) else $error("unknown address while valid");
    end

    task automatic drive(logic v, logic [2:0] a);
        @(negedge i_clk);
        valid = v;
        adr   = a;
    endtask

    task automatic afterEdge();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset held with a valid address present: outputs stay clear.
        i_rst = 1'b1;
        valid = 1'b1;
        adr   = 3'd5;
        #2;
        check("reset_immediate", outVec, 8'h00);
        for (int i = 0; i < 3; i++) begin
            afterEdge();
            check("reset_held", outVec, 8'h00);
        end

        // Release, then sweep every address.
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 3'(a));
            afterEdge();
            if (a == 3) check("sweep_adr3", outVec, 8'b0000_1000);
        end

        // Decode row 6, then drop valid.
        drive(1'b1, 3'd6);
        afterEdge();
        check("adr6", outVec, 8'b0100_0000);
        drive(1'b0, 3'd2);
        afterEdge();
        check("invalid", outVec, HOLD ? 8'b0100_0000 : 8'h00);

        // Back-to-back 7 then 0: select moves on a single edge.
        drive(1'b1, 3'd7);
        afterEdge();
        check("b2b_adr7", outVec, 8'b1000_0000);
        drive(1'b1, 3'd0);
        afterEdge();
        check("b2b_adr0", outVec, 8'b0000_0001);

        // Mid-operation reset between edges while row 2 is selected.
        drive(1'b1, 3'd2);
        afterEdge();
        check("pre_reset_adr2", outVec, 8'b0000_0100);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_reset", outVec, 8'h00);
        afterEdge();
        check("async_reset_held", outVec, 8'h00);
        @(negedge i_clk);
        i_rst = 1'b0;
        valid = 1'b1;
        adr   = 3'd4;
        afterEdge();
        check("post_reset_adr4", outVec, 8'b0001_0000);

        // Randomised traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(1, 8));
                i_rst = 1'b1;
                #1;
                check("rand_async_reset", outVec, 8'h00);
                @(negedge i_clk);
                i_rst = 1'b0;
            end
        end

        @(negedge i_clk);
        #1;
        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule : tb_sel_decode
